// File: rtl/carry_sel_pkg.sv
// Shared constants and helpers for the carry-select adder slice.
package carry_sel_pkg;

  localparam int CSA_WIDTH_DEF = 4;
  localparam int CSA_BLOCK_DEF = 2;

  // Number of carry-select blocks; callers guarantee block divides width.
  function automatic int csa_num_blocks(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/rca_block.sv
// Ripple-carry chain of BLOCK full adders; used for every carry-select segment.
module rca_block #(
  parameter int BLOCK = 2
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < BLOCK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[BLOCK];

endmodule

// File: rtl/carry_sel_adder.sv
// Registered carry-select adder: sout <= a + b + c at WIDTH+1 bits, one cycle latency.
module carry_sel_adder
  import carry_sel_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH_DEF,
  parameter int BLOCK = CSA_BLOCK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH:0]   sout,
  output logic             cout
);

  localparam int NB = csa_num_blocks(WIDTH, BLOCK);

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("carry_sel_adder: BLOCK must be >= 1 and divide WIDTH (>= 2)");
  end

  logic [NB:0]             w_carry;
  logic [NB-1:0][BLOCK-1:0] w_blk_sum;
  logic [WIDTH:0]          w_res;
  logic [WIDTH:0]          r_sout;

  assign w_carry[0] = c;

  rca_block #(.BLOCK(BLOCK)) u_blk0 (
    .a    (a[BLOCK-1:0]),
    .b    (b[BLOCK-1:0]),
    .cin  (w_carry[0]),
    .sum  (w_blk_sum[0]),
    .cout (w_carry[1])
  );

  // Upper blocks pre-compute both carry-in cases; the incoming carry picks one.
  for (genvar k = 1; k < NB; k++) begin : g_sel
    logic [BLOCK-1:0] w_s0, w_s1;
    logic             w_c0, w_c1;

    rca_block #(.BLOCK(BLOCK)) u_rca0 (
      .a    (a[k*BLOCK +: BLOCK]),
      .b    (b[k*BLOCK +: BLOCK]),
      .cin  (1'b0),
      .sum  (w_s0),
      .cout (w_c0)
    );

    rca_block #(.BLOCK(BLOCK)) u_rca1 (
      .a    (a[k*BLOCK +: BLOCK]),
      .b    (b[k*BLOCK +: BLOCK]),
      .cin  (1'b1),
      .sum  (w_s1),
      .cout (w_c1)
    );

    assign w_blk_sum[k] = w_carry[k] ? w_s1 : w_s0;
    assign w_carry[k+1] = w_carry[k] ? w_c1 : w_c0;
  end

  assign w_res = {w_carry[NB], w_blk_sum};

  always_ff @(posedge clk) begin
    if (rst) r_sout <= '0;
    else     r_sout <= w_res;
  end

  // cout is a view of the same register bit so the two can never disagree.
  assign sout = r_sout;
  assign cout = r_sout[WIDTH];

endmodule

// File: tb/tb_carry_sel_adder.sv
// Directed + exhaustive bench for carry_sel_adder with a scoreboard queue.
module tb_carry_sel_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a, b;
  logic         c;
  logic [W:0]   sout;
  logic         cout;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W:0] sb_q[$];

  carry_sel_adder #(.WIDTH(W), .BLOCK(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .c    (c),
    .sout (sout),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive one operation, push its expected result, clock it, then pop and compare.
  task automatic step(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic trst);
    logic [W:0] e;
    a = ta; b = tb_v; c = tc; rst = trst;
    if (trst) sb_q.push_back('0);
    else      sb_q.push_back({1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, "_sout"}, sout, e);
    check({tag, "_cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, e[W]});
    check({tag, "_cout_eq_msb"}, {{W{1'b0}}, cout}, {{W{1'b0}}, sout[W]});
  endtask

  initial begin
    logic [W:0] held;
    a = '0; b = '0; c = 1'b0; rst = 1'b1;

    step("rst0", 4'hF, 4'hF, 1'b1, 1'b1);
    step("rst1", 4'hF, 4'hF, 1'b1, 1'b1);
    step("rst_release", 4'hF, 4'hF, 1'b1, 1'b0);
    check("rst_release_const", sout, 5'b11111);

    step("carry_all", 4'b1111, 4'b0001, 1'b0, 1'b0);
    check("carry_all_const", sout, 5'b10000);
    step("mid_cin", 4'd5, 4'd3, 1'b1, 1'b0);
    check("mid_cin_const", sout, 5'b01001);
    step("cin_mux", 4'b0011, 4'b0000, 1'b1, 1'b0);
    check("cin_mux_const", sout, 5'b00100);

    step("b2b_0", 4'd1, 4'd2, 1'b0, 1'b0);
    check("b2b_0_const", sout, 5'd3);
    step("b2b_1", 4'd15, 4'd15, 1'b1, 1'b0);
    check("b2b_1_const", sout, 5'd31);
    step("b2b_2", 4'd8, 4'd8, 1'b0, 1'b0);
    check("b2b_2_const", sout, 5'd16);

    // Outputs must hold between edges regardless of input changes.
    held = sout;
    a = 4'd7; b = 4'd9; c = 1'b1;
    #2;
    a = 4'd0; b = 4'd0; c = 1'b0;
    #1;
    check("hold_between_edges", sout, held);

    for (int i = 0; i < 512; i++) begin
      if ($urandom_range(0, 19) == 0)
        step("exh_rst", 4'(i), 4'(i >> 4), i[8], 1'b1);
      step("exh", 4'(i), 4'(i >> 4), i[8], 1'b0);
    end

    step("rst_mid_stream", 4'hF, 4'h1, 1'b1, 1'b1);
    step("after_rst", 4'h2, 4'h3, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
